line_buffer_responder: RTL and testbench

- Responder for the word-granularity memory interface driven by the pipeline's L1 fetch/data ports.
- Serves 16-bit word and byte requests from a single 128-bit line buffer (one entry: 12-bit tag, valid, dirty).
- On a miss, acts as initiator toward the L2 cache's line-granularity interface (write-back of a dirty line, then fill).
- Sits between an L1 requester and L2; used as the bring-up memory front end and as a write-combining stage.

---
 rtl/line_buffer_responder.sv | 142 ++++++++++++++
 tb/tb_line_buffer_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_responder.sv
// Single-line (8 x 16-bit) buffer serving L1 word/byte requests, with
// write-back and fill toward the L2 line interface on a miss.
module line_buffer_responder #(
  parameter int unsigned LINE_WORDS       = 8,
  parameter bit          RESET_CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_wmask,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } state_t;

  state_t                       state_q, state_d;
  logic                         valid_q, valid_d;
  logic                         dirty_q, dirty_d;
  logic [11:0]                  tag_q, tag_d;
  logic [LINE_WORDS-1:0][15:0]  line_q, line_d;
  logic                         pmem_read_q, pmem_read_d;
  logic                         pmem_write_q, pmem_write_d;
  logic [11:0]                  pmem_tag_q, pmem_tag_d;

  logic [11:0] req_tag;
  logic [2:0]  word_off;
  logic        req;
  logic        hit;
  logic        unused_addr_lsb;

  assign req_tag         = mem_address[15:4];
  assign word_off        = mem_address[3:1];
  assign unused_addr_lsb = mem_address[0];
  assign req             = mem_read | mem_write;
  assign hit             = valid_q && (tag_q == req_tag);

  assign mem_rdata    = line_q[word_off];
  assign mem_resp     = (state_q == ST_IDLE) && req && hit;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = {pmem_tag_q, 4'h0};
  assign pmem_wdata   = line_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    line_d       = line_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_tag_d   = pmem_tag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            // Read+write together is a write.
            if (mem_write) begin
              if (mem_wmask[0]) line_d[word_off][7:0]  = mem_wdata[7:0];
              if (mem_wmask[1]) line_d[word_off][15:8] = mem_wdata[15:8];
              if (mem_wmask != 2'b00) dirty_d = 1'b1;
            end
          end else if (valid_q && dirty_q) begin
            state_d      = ST_WRITEBACK;
            pmem_write_d = 1'b1;
            pmem_tag_d   = tag_q;
          end else begin
            state_d     = ST_FILL;
            pmem_read_d = 1'b1;
            pmem_tag_d  = req_tag;
          end
        end
      end

      ST_WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d      = 1'b0;
          state_d      = ST_FILL;
          pmem_write_d = 1'b0;
          pmem_read_d  = 1'b1;
          pmem_tag_d   = req_tag;
        end
      end

      ST_FILL: begin
        if (pmem_resp) begin
          // Tag comes from the latched fill address so it always names the data fetched.
          line_d      = pmem_rdata;
          tag_d       = pmem_tag_q;
          valid_d     = 1'b1;
          dirty_d     = 1'b0;
          state_d     = ST_IDLE;
          pmem_read_d = 1'b0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      tag_q        <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_tag_q   <= '0;
      line_q       <= RESET_CLEAR_DATA ? '0 : line_q;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_tag_q   <= pmem_tag_d;
      line_q       <= line_d;
    end
  end

endmodule

// File: tb/tb_line_buffer_responder.sv
// Directed plus randomized bench for line_buffer_responder; the bench plays
// both the L1 requester and the L2 responder and keeps a flat memory view.
module tb_line_buffer_responder;

  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  line_buffer_responder #(
    .LINE_WORDS      (8),
    .RESET_CLEAR_DATA(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .pmem_address(pmem_address),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // L2 backing store and the buffered-line view the requester should observe.
  logic [127:0] l2 [int];
  logic         mvalid;
  logic         mdirty;
  logic [11:0]  mtag;
  logic [127:0] mline;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] l2_line(input int t);
    if (!l2.exists(t)) l2[t] = {$urandom, $urandom, $urandom, $urandom};
    return l2[t];
  endfunction

  function automatic logic [15:0] word_of(input logic [127:0] l, input int off);
    return l[off*16 +: 16];
  endfunction

  // Entered and left just after a rising edge while the DUT waits in WRITEBACK/FILL.
  task automatic serve(input bit is_wr, input logic [15:0] exp_addr,
                       input logic [127:0] exp_wdata, input int lat,
                       input logic [127:0] rdata);
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
      end
      @(negedge clk);
      check("pmem_read", pmem_read, !is_wr);
      check("pmem_write", pmem_write, is_wr);
      check("pmem_addr", pmem_address, exp_addr);
      check("wait_no_resp", mem_resp, 1'b0);
      if (is_wr) check("wb_data", pmem_wdata, exp_wdata);
      @(posedge clk); #1;
    end
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic access(input bit wr, input bit both, input logic [15:0] addr,
                        input logic [1:0] mask, input logic [15:0] wdata,
                        input int lat, output logic [15:0] got);
    int off;
    logic [127:0] fl;
    off = int'(addr[3:1]);
    mem_address = addr;
    mem_write   = wr;
    mem_read    = !wr || both;
    mem_wmask   = mask;
    mem_wdata   = wdata;
    if (!(mvalid && mtag == addr[15:4])) begin
      @(negedge clk);
      check("miss_silent", mem_resp, 1'b0);
      @(posedge clk); #1;
      if (mvalid && mdirty) begin
        serve(1'b1, {mtag, 4'h0}, mline, lat, '0);
        l2[int'(mtag)] = mline;
        mdirty = 1'b0;
      end
      fl = l2_line(int'(addr[15:4]));
      serve(1'b0, {addr[15:4], 4'h0}, '0, lat, fl);
      mvalid = 1'b1;
      mtag   = addr[15:4];
      mline  = fl;
      mdirty = 1'b0;
    end
    @(negedge clk);
    check("hit_resp", mem_resp, 1'b1);
    check("hit_rdata", mem_rdata, word_of(mline, off));
    check("hit_no_pmem", {pmem_read, pmem_write}, 2'b00);
    got = mem_rdata;
    @(posedge clk);
    if (wr) begin
      if (mask[0]) mline[off*16 +: 8]     = wdata[7:0];
      if (mask[1]) mline[off*16 + 8 +: 8] = wdata[15:8];
      if (mask != 2'b00) mdirty = 1'b1;
    end
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("resp_pulse", mem_resp, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got;
    logic [11:0] tags [4];
    logic [11:0] rt;
    tags[0] = 12'h123; tags[1] = 12'h456; tags[2] = 12'h200; tags[3] = 12'hABC;

    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wmask = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    mvalid = 1'b0; mdirty = 1'b0; mtag = '0; mline = '0;
    l2[12'h123] = 128'h7777_6666_5555_4444_BEEF_2222_1111_0A0A;
    l2[12'h200] = 128'h8888_7777_6666_5555_4444_3333_1234_1111;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_resp", mem_resp, 1'b0);
    check("rst_pmem", {pmem_read, pmem_write}, 2'b00);
    check("rst_paddr", pmem_address, 16'h0000);
    check("rst_rdata", mem_rdata, 16'h0000);
    @(posedge clk); #1;

    // Cold read miss, then hits and a byte merge.
    access(1'b0, 1'b0, 16'h1236, 2'b00, 16'h0000, 3, got);
    check("plan_beef", got, 16'hBEEF);
    access(1'b0, 1'b0, 16'h1230, 2'b00, 16'h0000, 0, got);
    check("plan_word0", got, 16'h0A0A);
    access(1'b1, 1'b0, 16'h1236, 2'b01, 16'h00AA, 0, got);
    access(1'b0, 1'b0, 16'h1236, 2'b00, 16'h0000, 0, got);
    check("plan_beaa", got, 16'hBEAA);

    // Dirty eviction then fill.
    access(1'b0, 1'b0, 16'h4560, 2'b00, 16'h0000, 2, got);
    check("evicted_word3", l2[12'h123][63:48], 16'hBEAA);

    // Write miss on a clean line.
    access(1'b1, 1'b0, 16'h2002, 2'b10, 16'h5500, 1, got);
    access(1'b0, 1'b0, 16'h2002, 2'b00, 16'h0000, 0, got);
    check("plan_5534", got, 16'h5534);

    // Reset while FILL is pending; the late L2 response must be ignored.
    mem_address = 16'h1230; mem_read = 1'b1;
    @(negedge clk);
    check("rmf_miss", mem_resp, 1'b0);
    @(posedge clk); #1;
    serve(1'b1, {mtag, 4'h0}, mline, 1, '0);
    l2[int'(mtag)] = mline;
    mdirty = 1'b0;
    @(negedge clk);
    check("rmf_in_fill", pmem_read, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mvalid = 1'b0; mdirty = 1'b0; mtag = '0; mline = '0;
    @(negedge clk);
    check("rmf_pread", pmem_read, 1'b0);
    check("rmf_resp", mem_resp, 1'b0);
    check("rmf_rdata", mem_rdata, 16'h0000);
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = {4{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("stale_pmem", {pmem_read, pmem_write}, 2'b00);
    check("stale_rdata", mem_rdata, 16'h0000);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 16'h1230, 2'b00, 16'h0000, 1, got);

    // Requester drops its request mid-fill: fill completes silently.
    mem_address = 16'h7778; mem_read = 1'b1;
    @(negedge clk);
    check("drop_miss", mem_resp, 1'b0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    serve(1'b0, 16'h7770, '0, 2, l2_line(12'h777));
    mvalid = 1'b1; mtag = 12'h777; mline = l2[12'h777]; mdirty = 1'b0;
    @(negedge clk);
    check("drop_no_resp", mem_resp, 1'b0);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 16'h777E, 2'b00, 16'h0000, 0, got);

    // Slow L2, then a zero-mask write must not dirty the line.
    access(1'b0, 1'b0, 16'hABC4, 2'b00, 16'h0000, 10, got);
    access(1'b1, 1'b0, 16'hABC4, 2'b00, 16'hFFFF, 0, got);
    check("mask00_old", got, word_of(l2[12'hABC], 2));
    access(1'b0, 1'b0, 16'hABC4, 2'b00, 16'h0000, 0, got);
    check("mask00_same", got, word_of(l2[12'hABC], 2));
    access(1'b0, 1'b0, 16'h3330, 2'b00, 16'h0000, 1, got);

    // Randomized traffic over a few lines to mix hits, merges and evictions.
    for (int i = 0; i < 200; i++) begin
      rt = tags[$urandom_range(0, 3)];
      access(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             {rt, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))},
             2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
